desp_sprite_fetch: RTL and testbench

// Pixel-fetch stage feeding the nine 64x64 4-bit desp*_rom sprite ROMs
// (stand, move, jump, crouch, block, punch, kick, crouchpunch, dead).
// Per VGA pixel it tests the beam against the fighter's box, forms the
// 12-bit ROM address with optional horizontal mirror, and selects the

---
 rtl/desp_sprite_fetch.sv | 148 ++++++++++++++
 tb/tb_desp_sprite_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/desp_sprite_fetch.sv
// desp_sprite_fetch: per-pixel fetch stage for the nine 64x64 4-bit fighter
// sprite ROMs. Tests the beam against the fighter box, forms the shared ROM
// address (optionally mirrored), picks the active pose's ROM nibble, and
// latches the pose once per frame with attack-hold and dead-sticky rules.
//
// Ports:
//   clock, reset_n         pixel clock, async active-low reset
//   frame_start            one-cycle pulse at start of vertical blank
//   draw_x, draw_y         beam position
//   pos_x, pos_y           sprite top-left
//   pose_req, facing_left  requested pose, horizontal mirror
//   rom_addr               registered address to all ROMs
//   rom_q                  packed ROM outputs, pose p at [4p+3:4p]
//   pix_idx, pix_valid     palette index and opaque flag, 3-cycle latency
//   pose_active            pose latched for the current frame
module desp_sprite_fetch #(
  parameter int unsigned SPR_W       = 64,
  parameter int unsigned SPR_H       = 64,
  parameter int unsigned HOLD_FRAMES = 12
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [3:0]  pose_req,
  input  logic        facing_left,
  output logic [11:0] rom_addr,
  input  logic [35:0] rom_q,
  output logic [3:0]  pix_idx,
  output logic        pix_valid,
  output logic [3:0]  pose_active
);

  localparam int unsigned HW     = $clog2(HOLD_FRAMES);
  localparam logic [10:0] W11    = 11'(SPR_W);
  localparam logic [10:0] H11    = 11'(SPR_H);
  localparam logic [3:0]  P_DEAD = 4'd8;

  typedef enum logic [1:0] {ST_LATCH, ST_HOLD, ST_DEAD} state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]     pose_q, pose_d;

  logic [11:0]    rom_addr_q, rom_addr_d;
  logic           in1_q, in1_d;
  logic [3:0]     tag1_q;
  logic           in2_q;
  logic [3:0]     tag2_q;
  logic [3:0]     pix_idx_q, pix_idx_d;
  logic           pix_valid_q, pix_valid_d;

  logic [10:0]    bx, by, px, py;
  logic [9:0]     dx, dy;
  logic [5:0]     col;

  // Stage 1: hit test in 11 bits so boxes past the right/bottom edge clip
  always_comb begin
    bx = {1'b0, draw_x};
    by = {1'b0, draw_y};
    px = {1'b0, pos_x};
    py = {1'b0, pos_y};
    dx = draw_x - pos_x;
    dy = draw_y - pos_y;
    in1_d = (bx >= px) && (bx < px + W11) && (by >= py) && (by < py + H11);
    col = facing_left ? ~dx[5:0] : dx[5:0];
    rom_addr_d = in1_d ? {dy[5:0], col} : '0;
  end

  // Stage 3: select the nibble of the pose tagged with this pixel
  always_comb begin
    pix_idx_d = '0;
    if (in2_q) begin
      for (int unsigned p = 0; p < 9; p++) begin
        if (tag2_q == 4'(p)) pix_idx_d = rom_q[4*p +: 4];
      end
    end
    pix_valid_d = in2_q && (pix_idx_d != '0);
  end

  // Pose latch: a dead request overrides an attack hold
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pose_d     = pose_q;
    if (frame_start) begin
      if (state_q != ST_DEAD && pose_req == P_DEAD) begin
        state_d    = ST_DEAD;
        pose_d     = P_DEAD;
        hold_cnt_d = '0;
      end else begin
        case (state_q)
          ST_HOLD: begin
            hold_cnt_d = hold_cnt_q - HW'(1);
            if (hold_cnt_q == HW'(1)) state_d = ST_LATCH;
          end
          ST_LATCH: begin
            if (pose_req < P_DEAD) begin
              pose_d = pose_req;
              if (pose_req >= 4'd5) begin
                hold_cnt_d = HW'(HOLD_FRAMES - 1);
                state_d    = ST_HOLD;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LATCH;
      hold_cnt_q  <= '0;
      pose_q      <= '0;
      rom_addr_q  <= '0;
      in1_q       <= 1'b0;
      tag1_q      <= '0;
      in2_q       <= 1'b0;
      tag2_q      <= '0;
      pix_idx_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      pose_q      <= pose_d;
      rom_addr_q  <= rom_addr_d;
      in1_q       <= in1_d;
      // tag takes the pose before any same-edge frame_start update, so
      // pixels already in flight keep the colour of the pose they started with
      tag1_q      <= pose_q;
      in2_q       <= in1_q;
      tag2_q      <= tag1_q;
      pix_idx_q   <= pix_idx_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign pix_idx     = pix_idx_q;
  assign pix_valid   = pix_valid_q;
  assign pose_active = pose_q;

endmodule

// File: tb/tb_desp_sprite_fetch.sv
module tb_desp_sprite_fetch;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  draw_x = '0, draw_y = '0, pos_x = '0, pos_y = '0;
  logic [3:0]  pose_req = '0;
  logic        facing_left = 1'b0;
  logic [11:0] rom_addr;
  logic [35:0] rom_q = '0;
  logic [3:0]  pix_idx;
  logic        pix_valid;
  logic [3:0]  pose_active;

  int tests = 0;
  int fails = 0;

  desp_sprite_fetch #(.SPR_W(64), .SPR_H(64), .HOLD_FRAMES(12)) dut (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
    .draw_x(draw_x), .draw_y(draw_y), .pos_x(pos_x), .pos_y(pos_y),
    .pose_req(pose_req), .facing_left(facing_left), .rom_addr(rom_addr),
    .rom_q(rom_q), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .pose_active(pose_active)
  );

  always #5 clock = ~clock;

  // ROM contents: nibble = (addr + pose) mod 16
  function automatic int rom_val(int p, int a);
    return (a + p) % 16;
  endfunction

  always @(posedge clock) begin : rom_blk
    logic [35:0] t;
    t = '0;
    for (int p = 0; p < 9; p++) t[4*p +: 4] = 4'(rom_val(p, int'(rom_addr)));
    rom_q <= t;
  end

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: history of the last three sampled pixels plus pose rules
  typedef struct { bit hit; int addr; int pose; } px_t;
  px_t hist[3];
  int  m_pose, m_hold;
  bit  m_dead;

  always @(posedge clock or negedge reset_n) begin : model
    px_t e;
    int dx, dy;
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0};
      m_pose = 0; m_hold = 0; m_dead = 0;
    end else begin
      dx = int'(draw_x) - int'(pos_x);
      dy = int'(draw_y) - int'(pos_y);
      e.hit  = (dx >= 0) && (dx < 64) && (dy >= 0) && (dy < 64);
      e.addr = e.hit ? dy * 64 + (facing_left ? 63 - dx : dx) : 0;
      e.pose = m_pose;
      hist[0] = hist[1];
      hist[1] = hist[2];
      hist[2] = e;
      if (frame_start && !m_dead) begin
        if (pose_req == 8) begin
          m_pose = 8; m_dead = 1; m_hold = 0;
        end else if (m_hold > 0) begin
          m_hold--;
        end else if (pose_req < 8) begin
          m_pose = int'(pose_req);
          if (m_pose >= 5) m_hold = 11;
        end
      end
    end
  end

  always @(posedge clock) begin : compare
    int ei;
    #1;
    ei = hist[0].hit ? rom_val(hist[0].pose, hist[0].addr) : 0;
    chk("m_rom_addr", int'(rom_addr), hist[2].addr);
    chk("m_pix_idx", int'(pix_idx), ei);
    chk("m_pix_valid", int'(pix_valid), int'(ei != 0));
    chk("m_pose_active", int'(pose_active), m_pose);
  end

  // Drive one pixel (called at edge+2), check address and 3-cycle output
  task automatic probe(string nm, int x, int y, int ea, int ei, int ev);
    draw_x = 10'(x);
    draw_y = 10'(y);
    @(posedge clock); #1;
    chk({nm, "_addr"}, int'(rom_addr), ea);
    @(posedge clock);
    @(posedge clock); #1;
    chk({nm, "_idx"}, int'(pix_idx), ei);
    chk({nm, "_valid"}, int'(pix_valid), ev);
    #1;
  endtask

  task automatic frame(int req, int ep);
    pose_req = 4'(req);
    frame_start = 1'b1;
    @(posedge clock); #1;
    chk("pose_latch", int'(pose_active), ep);
    #1;
    frame_start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pos_x = 10'd100; pos_y = 10'd50;
    draw_x = 10'd0; draw_y = 10'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_addr", int'(rom_addr), 0);
    chk("reset_valid", int'(pix_valid), 0);
    chk("reset_pose", int'(pose_active), 0);
    #1 reset_n = 1'b1;

    // T1: corners, exact latency
    probe("t1_origin", 100, 50, 0, 0, 0);
    probe("t1_corner", 163, 113, 4095, 15, 1);
    // T2: mirrored
    facing_left = 1'b1;
    probe("t2_left", 100, 51, 127, 15, 1);
    probe("t2_right", 163, 51, 64, 0, 0);
    facing_left = 1'b0;
    // T3: box edges and right-edge clipping
    probe("t3_x_lo", 99, 50, 0, 0, 0);
    probe("t3_x_hi", 164, 50, 0, 0, 0);
    probe("t3_y_hi", 100, 114, 0, 0, 0);
    pos_x = 10'd600;
    probe("t3_clip_in", 639, 50, 39, 7, 1);
    probe("t3_nowrap0", 0, 50, 0, 0, 0);
    probe("t3_nowrap23", 23, 50, 0, 0, 0);
    pos_x = 10'd100;
    // T4: transparent vs opaque
    probe("t4_opaque", 110, 50, 10, 10, 1);
    probe("t4_transp", 116, 50, 16, 0, 0);

    // T5: attack hold, dead override, pixels in flight across frame_start
    draw_x = 10'd105; draw_y = 10'd55;
    frame(6, 6);
    for (int i = 0; i < 11; i++) frame(0, 6);
    frame(0, 0);
    frame(6, 6);
    frame(0, 6);
    frame(8, 8);
    frame(0, 8);
    frame(3, 8);

    // T6: async reset mid-line
    draw_x = 10'd163; draw_y = 10'd113;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_addr", int'(rom_addr), 0);
    chk("t6_async_idx", int'(pix_idx), 0);
    chk("t6_async_valid", int'(pix_valid), 0);
    chk("t6_async_pose", int'(pose_active), 0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("t6_rel_addr", int'(rom_addr), 4095);
    chk("t6_rel_v1", int'(pix_valid), 0);
    @(posedge clock); #1;
    chk("t6_rel_v2", int'(pix_valid), 0);
    @(posedge clock); #1;
    chk("t6_rel_v3", int'(pix_valid), 1);
    chk("t6_rel_idx", int'(pix_idx), 15);
    #1;
    frame(3, 3);
    frame(9, 3);
    frame(12, 3);

    // Sweeps across edges, checked by the model every cycle
    pos_x = 10'd600;
    facing_left = 1'b1;
    draw_y = 10'd50;
    for (int x = 590; x < 664; x++) begin
      draw_x = 10'(x % 640);
      @(posedge clock); #2;
    end
    pos_x = 10'd100;
    facing_left = 1'b0;
    foreach (hist[i]) begin end
    for (int yi = 0; yi < 4; yi++) begin
      draw_y = (yi == 0) ? 10'd49 : (yi == 1) ? 10'd50 : (yi == 2) ? 10'd113 : 10'd114;
      for (int x = 95; x < 171; x += 3) begin
        draw_x = 10'(x);
        facing_left = x[0];
        @(posedge clock); #2;
      end
    end
    repeat (4) @(posedge clock);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
